// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory interface.
// Accepts one load/store at a time over req_valid/req_ready, waits LATENCY
// cycles, then returns read data or a write acknowledge over resp_valid/resp_ready.
// The store is word-organised (64-bit words), little-endian and byte-maskable.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When defined, a request whose
// byte address is not 8-byte aligned performs no access and responds with
// resp_err=1. When undefined, the low three address bits are ignored.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_bmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 3);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    write_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [63:0]             wdata_reg;
    logic [7:0]              bmask_reg;
    logic                    resp_valid_reg;
    logic [63:0]             resp_rdata_reg;
    logic                    resp_err_reg;

    logic [63:0] mem [DEPTH];

    // Access request for the edge that enters RESP
    logic                  acc_fire;
    logic                  acc_write;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [63:0]           acc_wdata;
    logic [7:0]            acc_bmask;
    logic                  acc_ok;

    // With a single-cycle latency the access happens on the acceptance edge,
    // so it must use the request inputs directly rather than the latched copy.
    generate
        if (LATENCY == 1) begin : g_direct
            always_comb begin
                acc_fire  = (state_reg == IDLE) && req_valid && !reset;
                acc_write = req_write;
                acc_addr  = req_addr[ADDR_WIDTH-1:0];
                acc_wdata = req_wdata;
                acc_bmask = req_bmask;
            end
        end else begin : g_latched
            // Counter value 1 means this is the last WAIT edge: the access
            // lands on edge T+LATENCY-1 after acceptance at edge T.
            always_comb begin
                acc_fire  = (state_reg == WAIT) && (cnt_reg == 4'd1) && !reset;
                acc_write = write_reg;
                acc_addr  = addr_reg;
                acc_wdata = wdata_reg;
                acc_bmask = bmask_reg;
            end
        end
    endgenerate

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_ok = (acc_addr[2:0] == 3'b000);
`else
    assign acc_ok = 1'b1;
`endif

    // Byte-masked store into the word array; contents are never reset
    always_ff @(posedge clk) begin
        if (acc_fire && acc_write && acc_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (acc_bmask[b]) begin
                    mem[acc_addr[ADDR_WIDTH-1:3]][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 64'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        addr_reg  <= req_addr[ADDR_WIDTH-1:0];
                        wdata_reg <= req_wdata;
                        bmask_reg <= req_bmask;
                        cnt_reg   <= 4'(LATENCY - 1);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (acc_fire) begin
                state_reg      <= RESP;
                resp_valid_reg <= 1'b1;
                resp_rdata_reg <= (acc_write || !acc_ok) ? 64'd0
                                                          : mem[acc_addr[ADDR_WIDTH-1:3]];
                resp_err_reg   <= !acc_ok;
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    // Address bits above the decoded range alias; some latched fields are
    // only consumed in particular build configurations.
    logic unused_bits;
    assign unused_bits = ^{req_addr[63:ADDR_WIDTH], acc_addr[2:0], write_reg,
                           addr_reg, wdata_reg, bmask_reg};

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (ADDR_WIDTH=10, LATENCY=3). Honours DMEM_MISALIGN_CHECK_EN when defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_bmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_bmask  (req_bmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One full request/response transaction; hold = cycles of resp_ready=0
    task automatic do_req(input string tag, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] m,
                          input logic [63:0] exp_d, input logic exp_e, input int hold);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        check({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_bmask = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        req_bmask = 8'hFF;
        while (lat < 20 && !seen) begin
            @(negedge clk);
            lat++;
            if (resp_valid) seen = 1;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
        check({tag, " rdata"}, resp_rdata, exp_d);
        check({tag, " err"}, {63'd0, resp_err}, {63'd0, exp_e});
        check({tag, " busy"}, {63'd0, busy}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, {63'd0, resp_valid}, 64'd1);
            check({tag, " hold rdata"}, resp_rdata, exp_d);
            check({tag, " hold req_ready"}, {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " post valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, " post req_ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, " post rdata held"}, resp_rdata, exp_d);
        $display("txn %s write=%0d addr=%h rdata=%h err=%0d lat=%0d",
                 tag, w, a, resp_rdata, resp_err, lat);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_bmask  = 8'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst req_ready", {63'd0, req_ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst rdata", resp_rdata, 64'd0);
        check("rst err", {63'd0, resp_err}, 64'd0);
        $display("txn reset done");

        // Full store then load
        do_req("st10", 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0, 0);
        do_req("ld10", 1'b0, 64'h10, 64'd0, 8'h00, 64'h1122334455667788, 1'b0, 0);

        // Partial byte mask over prior value
        do_req("st10m", 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, 1'b0, 0);
        do_req("ld10m", 1'b0, 64'h10, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, 0);

        // Backpressure on a load response
        do_req("ldbp", 1'b0, 64'h10, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, 5);

        // Reset during WAIT discards the pending store
        do_req("st20", 1'b1, 64'h20, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hDEAD;
        req_bmask = 8'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort req_ready", {63'd0, req_ready}, 64'd1);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort resp_valid", {63'd0, resp_valid}, 64'd0);
        check("abort rdata", resp_rdata, 64'd0);
        $display("txn reset-abort store addr=%h", 64'h20);
        do_req("ld20", 1'b0, 64'h20, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 0);

        // Upper address bits alias
        do_req("st408", 1'b1, 64'h408, 64'h5A, 8'hFF, 64'd0, 1'b0, 0);
        do_req("ld08", 1'b0, 64'h08, 64'd0, 8'h00, 64'h5A, 1'b0, 0);

        // Misaligned store
`ifdef DMEM_MISALIGN_CHECK_EN
        do_req("st13", 1'b1, 64'h13, 64'h5555555555555555, 8'hFF, 64'd0, 1'b1, 0);
        do_req("ld10a", 1'b0, 64'h10, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, 0);
`else
        do_req("st13", 1'b1, 64'h13, 64'h5555555555555555, 8'hFF, 64'd0, 1'b0, 0);
        do_req("ld10a", 1'b0, 64'h10, 64'd0, 8'h00, 64'h5555555555555555, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
